// File: rtl/commu_tx.sv
`timescale 1ns/1ps
// commu_tx: UART 8N1 byte transmitter for one RS-485 port, with driver-enable
// lead/tail timing around each packet and in-packet underrun detection.
module commu_tx #(
   parameter int DIV     = 100,
   parameter int DE_LEAD = 16,
   parameter int DE_TAIL = 16,
   parameter int GAP_MAX = 1000
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_vld,
   input  logic       tx_last,
   output logic       tx_rdy,
   output logic       tx,
   output logic       de,
   output logic       busy,
   output logic       underrun
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEAD  = 3'd1,
      S_START = 3'd2,
      S_DATA  = 3'd3,
      S_STOP  = 3'd4,
      S_GAP   = 3'd5,
      S_TAIL  = 3'd6
   } state_t;

   localparam logic [15:0] DIV_END  = 16'(DIV - 1);
   localparam logic [15:0] LEAD_END = 16'(DE_LEAD - 1);
   localparam logic [15:0] TAIL_END = 16'(DE_TAIL - 1);
   localparam logic [15:0] GAP_END  = 16'(GAP_MAX - 1);

   state_t      state_r, state_s;
   logic [15:0] cnt_r, cnt_s;
   logic [2:0]  bit_r, bit_s;
   logic [7:0]  shift_r, shift_s;
   logic        last_r, last_s;
   logic [7:0]  hold_data_r, hold_data_s;
   logic        hold_last_r, hold_last_s;
   logic        hold_vld_r, hold_vld_s;
   logic        load_s, accept_s, underrun_s, tx_s;

   // Next-state logic: one shared counter times every phase and restarts at each boundary
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r + 16'd1;
      bit_s      = bit_r;
      shift_s    = shift_r;
      last_s     = last_r;
      load_s     = 1'b0;
      underrun_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            cnt_s = 16'd0;
            if (hold_vld_r) state_s = S_LEAD;
            else            state_s = S_IDLE;
         end
         S_LEAD: begin
            if (cnt_r == LEAD_END) begin
               state_s = S_START;
               cnt_s   = 16'd0;
               load_s  = 1'b1;
            end else begin
               state_s = S_LEAD;
            end
         end
         S_START: begin
            if (cnt_r == DIV_END) begin
               state_s = S_DATA;
               cnt_s   = 16'd0;
               bit_s   = 3'd0;
            end else begin
               state_s = S_START;
            end
         end
         S_DATA: begin
            if (cnt_r == DIV_END) begin
               cnt_s   = 16'd0;
               shift_s = {1'b0, shift_r[7:1]};
               if (bit_r == 3'd7) begin
                  state_s = S_STOP;
               end else begin
                  bit_s = bit_r + 3'd1;
               end
            end else begin
               state_s = S_DATA;
            end
         end
         S_STOP: begin
            if (cnt_r == DIV_END) begin
               cnt_s = 16'd0;
               // A held byte after a last=1 frame belongs to a new packet and waits for IDLE
               if (last_r) begin
                  state_s = S_TAIL;
               end else if (hold_vld_r) begin
                  state_s = S_START;
                  load_s  = 1'b1;
               end else begin
                  state_s = S_GAP;
               end
            end else begin
               state_s = S_STOP;
            end
         end
         S_GAP: begin
            if (hold_vld_r) begin
               state_s = S_START;
               cnt_s   = 16'd0;
               load_s  = 1'b1;
            end else if (cnt_r == GAP_END) begin
               state_s    = S_TAIL;
               cnt_s      = 16'd0;
               underrun_s = 1'b1;
            end else begin
               state_s = S_GAP;
            end
         end
         S_TAIL: begin
            if (cnt_r == TAIL_END) begin
               state_s = S_IDLE;
               cnt_s   = 16'd0;
            end else begin
               state_s = S_TAIL;
            end
         end
         default: begin
            state_s = S_IDLE;
            cnt_s   = 16'd0;
         end
      endcase
      if (load_s) begin
         shift_s = hold_data_r;
         last_s  = hold_last_r;
         bit_s   = 3'd0;
      end else begin
         last_s = last_r;
      end
   end

   // Holding register: accept only when empty, release on load into the shifter
   always_comb begin
      accept_s    = tx_vld & ~hold_vld_r;
      hold_data_s = hold_data_r;
      hold_last_s = hold_last_r;
      hold_vld_s  = hold_vld_r;
      if (accept_s) begin
         hold_data_s = tx_data;
         hold_last_s = tx_last;
         hold_vld_s  = 1'b1;
      end else if (load_s) begin
         hold_vld_s = 1'b0;
      end else begin
         hold_vld_s = hold_vld_r;
      end
   end

   // Serial line value for the upcoming cycle
   always_comb begin
      case (state_s)
         S_START: tx_s = 1'b0;
         S_DATA:  tx_s = shift_s[0];
         default: tx_s = 1'b1;
      endcase
   end

   // State and output registers; reset forces the line idle and the driver off at once
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         cnt_r       <= 16'd0;
         bit_r       <= 3'd0;
         shift_r     <= 8'd0;
         last_r      <= 1'b0;
         hold_data_r <= 8'd0;
         hold_last_r <= 1'b0;
         hold_vld_r  <= 1'b0;
         tx_rdy      <= 1'b1;
         tx          <= 1'b1;
         de          <= 1'b0;
         busy        <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         bit_r       <= bit_s;
         shift_r     <= shift_s;
         last_r      <= last_s;
         hold_data_r <= hold_data_s;
         hold_last_r <= hold_last_s;
         hold_vld_r  <= hold_vld_s;
         tx_rdy      <= ~hold_vld_s;
         tx          <= tx_s;
         de          <= (state_s != S_IDLE);
         busy        <= (state_s != S_IDLE);
         underrun    <= underrun_s;
      end
   end

endmodule
